mat_frame_buffer: RTL and testbench

- Double-buffered frame store for the 8x8 bicolor LED matrix.
- Sits directly upstream of the matrix scan driver. The driver reads the front buffer one row word per colour.
- Pattern logic writes whole row words into the back buffer, then requests a swap.
- The swap is deferred to the driver's frame boundary so that a displayed frame never tears.

---
 rtl/mat_frame_buffer.sv | 89 ++++++++
 tb/tb_mat_frame_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mat_frame_buffer.sv
// mat_frame_buffer: double-buffered 8x8 bicolor frame store with frame-aligned swap and back-buffer clear
module mat_frame_buffer #(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int COLORS = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [$clog2(COLORS)-1:0]   wr_color,
   input  logic [$clog2(ROWS)-1:0]     wr_row,
   input  logic [COLS-1:0]             wr_data,
   output logic                        wr_ready,
   input  logic                        clr_req,
   input  logic                        swap_req,
   output logic                        swap_ack,
   input  logic                        frame_start,
   input  logic [$clog2(COLORS)-1:0]   rd_color,
   input  logic [$clog2(ROWS)-1:0]     rd_row,
   output logic [COLS-1:0]             rd_data,
   output logic                        front_sel
);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLORS);
   localparam int NW = RW + CW;
   localparam logic [NW-1:0] LAST = NW'(COLORS * ROWS - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

   state_t          r_state;
   logic [NW-1:0]   r_cnt;
   logic            r_front_sel;
   logic            r_swap_ack;
   logic [COLS-1:0] r_rd_data;
   logic [COLS-1:0] r_mem [2][COLORS][ROWS];
   logic            w_back;

   assign w_back    = ~r_front_sel;
   assign wr_ready  = r_state == IDLE;
   assign swap_ack  = r_swap_ack;
   assign front_sel = r_front_sel;
   assign rd_data   = r_rd_data;

   // Control FSM: clear beats swap; a swap only completes on a frame_start seen while waiting
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_front_sel <= 1'b0;
         r_swap_ack  <= 1'b0;
      end else begin
         r_swap_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (clr_req) r_state <= CLEAR;
               else if (swap_req) r_state <= SWAP_WAIT;
            end
            CLEAR: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST) r_state <= IDLE;
            end
            SWAP_WAIT:
               if (frame_start) begin
                  r_front_sel <= ~r_front_sel;
                  r_swap_ack  <= 1'b1;
                  r_state     <= IDLE;
               end
            default: r_state <= IDLE;
         endcase
      end

   // Back-buffer storage: pattern writes while idle, one word zeroed per cycle while clearing
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int c = 0; c < COLORS; c++)
               for (int r = 0; r < ROWS; r++)
                  r_mem[b][c][r] <= '0;
      end else if (r_state == IDLE && wr_en)
         r_mem[w_back][wr_color][wr_row] <= wr_data;
      else if (r_state == CLEAR)
         r_mem[w_back][r_cnt[RW +: CW]][r_cnt[RW-1:0]] <= '0;

   // Front-buffer read port, one cycle latency, always enabled
   always_ff @(posedge clk or posedge rst)
      if (rst) r_rd_data <= '0;
      else r_rd_data <= r_mem[r_front_sel][rd_color][rd_row];
endmodule

// File: tb/tb_mat_frame_buffer.sv
// tb_mat_frame_buffer: directed scoreboard bench for the double-buffered LED frame store
module tb_mat_frame_buffer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0, wr_color = 1'b0, clr_req = 1'b0, swap_req = 1'b0, frame_start = 1'b0;
   logic       rd_color = 1'b0;
   logic [2:0] wr_row = '0, rd_row = '0;
   logic [7:0] wr_data = '0, rd_data;
   logic       wr_ready, swap_ack, front_sel;

   int         n_tests = 0, n_fail = 0;
   logic [7:0] m [2][2][8];
   int         mf = 0;
   logic [7:0] q [$];

   mat_frame_buffer dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_color(wr_color), .wr_row(wr_row),
      .wr_data(wr_data), .wr_ready(wr_ready), .clr_req(clr_req), .swap_req(swap_req),
      .swap_ack(swap_ack), .frame_start(frame_start), .rd_color(rd_color),
      .rd_row(rd_row), .rd_data(rd_data), .front_sel(front_sel)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int c = 0; c < 2; c++)
            for (int r = 0; r < 8; r++)
               m[b][c][r] = 8'h00;
      mf = 0;
   endtask

   task automatic model_clear_back();
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 8; r++)
            m[1-mf][c][r] = 8'h00;
   endtask

   task automatic wr(input int c, input int r, input logic [7:0] d);
      wr_en = 1'b1; wr_color = c[0]; wr_row = r[2:0]; wr_data = d;
      m[1-mf][c][r] = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input string tag, input int c, input int r);
      rd_color = c[0]; rd_row = r[2:0];
      q.push_back(m[mf][c][r]);
      tick();
      chk(tag, rd_data, q.pop_front());
   endtask

   task automatic rd_all(input string tag);
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 8; r++)
            rd(tag, c, r);
   endtask

   task automatic do_swap(input string tag);
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      tick();
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      mf = 1 - mf;
      chk({tag, "_ack"}, {7'd0, swap_ack}, 8'd1);
      chk({tag, "_front"}, {7'd0, front_sel}, 8'(mf));
      tick();
      chk({tag, "_ack_low"}, {7'd0, swap_ack}, 8'd0);
   endtask

   initial begin
      model_reset();
      // reset state, checked while reset is held
      tick(); tick();
      chk("rst_ready", {7'd0, wr_ready}, 8'd1);
      chk("rst_ack", {7'd0, swap_ack}, 8'd0);
      chk("rst_front", {7'd0, front_sel}, 8'd0);
      chk("rst_rd", rd_data, 8'h00);
      rst = 1'b0;
      tick();
      rd_all("rst_read");

      // write then swap
      wr(0, 2, 8'h88);
      wr(1, 5, 8'h0F);
      rd("pre_swap_02", 0, 2);
      rd("pre_swap_15", 1, 5);
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      chk("sw_ready_low", {7'd0, wr_ready}, 8'd0);
      for (int i = 0; i < 10; i++) begin
         chk("sw_wait_front", {7'd0, front_sel}, 8'd0);
         chk("sw_wait_ack", {7'd0, swap_ack}, 8'd0);
         tick();
      end
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      mf = 1;
      chk("sw_ack", {7'd0, swap_ack}, 8'd1);
      chk("sw_front", {7'd0, front_sel}, 8'd1);
      tick();
      chk("sw_ack_once", {7'd0, swap_ack}, 8'd0);
      chk("sw_ready_back", {7'd0, wr_ready}, 8'd1);
      rd("post_swap_02", 0, 2);
      rd("post_swap_15", 1, 5);
      rd("post_swap_00", 0, 0);

      // swap requested together with frame_start waits for the next boundary
      swap_req = 1'b1; frame_start = 1'b1; tick(); swap_req = 1'b0; frame_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_color = 1'b0; wr_row = 3'(i); wr_data = 8'hAA;
         chk("bnd_ready_low", {7'd0, wr_ready}, 8'd0);
         chk("bnd_front", {7'd0, front_sel}, 8'd1);
         chk("bnd_ack", {7'd0, swap_ack}, 8'd0);
         tick();
      end
      wr_en = 1'b0;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      mf = 0;
      chk("bnd_ack", {7'd0, swap_ack}, 8'd1);
      chk("bnd_front_new", {7'd0, front_sel}, 8'd0);
      tick();
      for (int r = 0; r < 5; r++) rd("bnd_ignored", 0, r);

      // clear sweep of a fully lit back buffer
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 8; r++)
            wr(c, r, 8'hFF);
      clr_req = 1'b1; tick(); clr_req = 1'b0;
      model_clear_back();
      for (int i = 0; i < 16; i++) begin
         chk("clr_busy", {7'd0, wr_ready}, 8'd0);
         frame_start = (i == 4);
         swap_req = (i == 6);
         tick();
      end
      frame_start = 1'b0; swap_req = 1'b0;
      chk("clr_done", {7'd0, wr_ready}, 8'd1);
      chk("clr_no_ack", {7'd0, swap_ack}, 8'd0);
      chk("clr_front", {7'd0, front_sel}, 8'd0);
      do_swap("clr_swap");
      rd_all("clr_read");

      // simultaneous clear and swap, with a write landing first
      wr_en = 1'b1; wr_color = 1'b1; wr_row = 3'd3; wr_data = 8'h5A;
      clr_req = 1'b1; swap_req = 1'b1;
      tick();
      wr_en = 1'b0; clr_req = 1'b0; swap_req = 1'b0;
      model_clear_back();
      for (int i = 0; i < 16; i++) tick();
      chk("sim_ready", {7'd0, wr_ready}, 8'd1);
      for (int i = 0; i < 2; i++) begin
         frame_start = 1'b1; tick(); frame_start = 1'b0;
         tick();
         chk("sim_no_ack", {7'd0, swap_ack}, 8'd0);
         chk("sim_front", {7'd0, front_sel}, 8'd1);
      end
      do_swap("sim_swap");
      rd("sim_cleared_13", 1, 3);

      // reset during CLEAR at counter 7
      wr(0, 1, 8'h33);
      do_swap("pre_rst_swap");
      rd("pre_rst_01", 0, 1);
      wr(1, 6, 8'hC3);
      clr_req = 1'b1; tick(); clr_req = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      rst = 1'b1; #1;
      model_reset();
      chk("rst_clr_ready", {7'd0, wr_ready}, 8'd1);
      chk("rst_clr_front", {7'd0, front_sel}, 8'd0);
      chk("rst_clr_rd", rd_data, 8'h00);
      tick(); rst = 1'b0;
      tick();
      chk("rst_clr_no_ack", {7'd0, swap_ack}, 8'd0);
      rd_all("rst_clr_read");

      // reset during SWAP_WAIT
      wr(1, 4, 8'h7E);
      do_swap("pre_rst2_swap");
      rd("pre_rst2_14", 1, 4);
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      tick(); tick();
      chk("rst_sw_busy", {7'd0, wr_ready}, 8'd0);
      rst = 1'b1; #1;
      model_reset();
      chk("rst_sw_ready", {7'd0, wr_ready}, 8'd1);
      chk("rst_sw_front", {7'd0, front_sel}, 8'd0);
      chk("rst_sw_ack", {7'd0, swap_ack}, 8'd0);
      chk("rst_sw_rd", rd_data, 8'h00);
      tick(); rst = 1'b0;
      tick();
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      tick();
      chk("rst_sw_no_ack", {7'd0, swap_ack}, 8'd0);
      chk("rst_sw_front2", {7'd0, front_sel}, 8'd0);
      rd("rst_sw_read0", 1, 4);
      do_swap("post_rst_swap");
      rd_all("rst_sw_read1");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
